// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampling, valid/ready output with framing and sticky overrun flags
module uart_rx #(
  parameter int CLK_F = 25000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);
  localparam int DIV = CLK_F / (BAUD_RATE * 16);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state;
  logic [1:0] sync;
  logic [DW-1:0] div_cnt;
  logic [3:0] os_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic rx_s, tick, mid, last, done, xfer;
  assign rx_s = sync[1];
  assign tick = state != IDLE && div_cnt == DW'(DIV - 1);
  assign mid = tick && os_cnt == 4'd7;
  assign last = tick && os_cnt == 4'd15;
  assign done = last && state == STOP && rx_s;
  assign xfer = rx_valid && rx_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b11;
      state <= IDLE;
      div_cnt <= '0;
      os_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      os_cnt <= (state == IDLE || (state == START && mid)) ? '0 : os_cnt + 4'(tick);
      case (state)
        IDLE: if (!rx_s) state <= START;
        START: if (mid) state <= rx_s ? IDLE : DATA;
        DATA: if (last && bit_idx == 3'd7) state <= STOP;
        default: if (last) state <= IDLE;
      endcase
      if (state == START) bit_idx <= '0;
      else if (state == DATA && last) bit_idx <= bit_idx + 1'b1;
      if (state == DATA && last) shift[bit_idx] <= rx_s;
      frame_err <= last && state == STOP && !rx_s;
      // a completed byte wins the output register only if the previous one is gone or leaving now
      rx_valid <= done || (rx_valid && !xfer);
      if (done && (!rx_valid || xfer)) rx_data <= shift;
      if (done && rx_valid && !xfer) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level behavioural model
module tb_uart_rx;
  localparam int CLK_F = 1_600_000, BAUD = 25_000;
  localparam int DIV = CLK_F / (BAUD * 16);
  localparam int BIT = 16 * DIV;
  localparam int LAT = 152 * DIV + 3;
  logic clk = 0, reset = 0, rx = 1, rx_ready = 0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun;
  int cyc = 0, n_chk = 0, n_fail = 0, fe_cnt = 0, last_start = 0, last_rise = 0;
  typedef struct { int at; logic [7:0] b; bit ok; } fr_t;
  fr_t pend[$];
  fr_t cur;
  logic [7:0] acc[$];
  logic [7:0] exp3[3] = '{8'h00, 8'hFF, 8'h81};
  logic mv = 0, mfe = 0, mo = 0, rdy_q = 0, pv = 0, hit, ok_done, xf;
  logic [7:0] md = 0;
  bit rnd_done = 0;
  uart_rx #(.CLK_F(CLK_F), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Model: every frame completes a fixed latency after its start edge; outputs follow the valid/ready rules
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      mv = 0; md = 0; mo = 0; mfe = 0;
      pend.delete();
    end else begin
      hit = pend.size() > 0 && pend[0].at == cyc;
      if (hit) cur = pend.pop_front();
      ok_done = hit && cur.ok;
      xf = mv && rdy_q;
      if (ok_done && (!mv || xf)) md = cur.b;
      if (ok_done && mv && !xf) mo = 1;
      mv = ok_done || (mv && !xf);
      mfe = hit && !cur.ok;
    end
    n_chk++;
    if ({rx_valid, rx_data, frame_err, overrun} !== {mv, md, mfe, mo}) begin
      n_fail++;
      $display("FAIL cycle_check @%0d: dut v=%b d=%h fe=%b ov=%b, model v=%b d=%h fe=%b ov=%b",
               cyc, rx_valid, rx_data, frame_err, overrun, mv, md, mfe, mo);
    end
    if (rx_valid && !pv) last_rise = cyc;
    pv = rx_valid;
    fe_cnt += int'(frame_err);
    if (rx_valid && rx_ready) acc.push_back(rx_data);
    rdy_q = rx_ready;
  end
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #2;
  endtask
  // Called at posedge+2; rb >= 0 pulses reset in the middle of data bit rb and abandons the frame
  task automatic send_frame(input logic [7:0] b, input bit ok, input int rb);
    logic [9:0] f;
    f = {ok, b, 1'b0};
    last_start = cyc;
    pend.push_back('{cyc + LAT, b, ok});
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      if (rb >= 0 && i == rb + 1) begin
        idle(BIT / 2);
        reset = 0;
        idle(3);
        reset = 1;
        rx = 1;
        idle(BIT);
        return;
      end
      idle(BIT);
    end
    if (!ok) begin
      rx = 1;
      idle(2 * BIT);
    end
  endtask
  task automatic glitch(input int g);
    rx = 0;
    idle(g);
    rx = 1;
    idle(BIT);
  endtask
  initial begin
    idle(4);
    reset = 1;
    idle(2);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    send_frame(8'hA5, 1, -1);
    n_chk++;
    if (last_rise - last_start < 152 * DIV + 2 || last_rise - last_start > 152 * DIV + 4) begin
      n_fail++;
      $display("FAIL latency: got %0d clk, expected %0d..%0d", last_rise - last_start, 152 * DIV + 2, 152 * DIV + 4);
    end
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1);
    chk("a5_ferr_cnt", fe_cnt, 0);
    rx_ready = 1;
    idle(1);
    rx_ready = 0;
    chk("consume_valid", rx_valid, 0);
    glitch(4 * DIV);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_data", rx_data, 8'hA5);
    chk("glitch_ferr_cnt", fe_cnt, 0);
    send_frame(8'h3C, 0, -1);
    chk("ferr_pulses", fe_cnt, 1);
    chk("ferr_valid", rx_valid, 0);
    chk("ferr_data", rx_data, 8'hA5);
    send_frame(8'h11, 1, -1);
    send_frame(8'h22, 1, -1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_flag", overrun, 1);
    rx_ready = 1;
    idle(1);
    rx_ready = 0;
    chk("ovr_consume_valid", rx_valid, 0);
    chk("ovr_sticky", overrun, 1);
    send_frame(8'hFF, 1, 4);
    chk("midrst_data", rx_data, 0);
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_ovr", overrun, 0);
    send_frame(8'h5A, 1, -1);
    chk("after_rst_data", rx_data, 8'h5A);
    chk("after_rst_valid", rx_valid, 1);
    chk("after_rst_ovr", overrun, 0);
    rx_ready = 1;
    idle(2);
    acc.delete();
    for (int i = 0; i < 3; i++) send_frame(exp3[i], 1, -1);
    chk("stream_count", acc.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("stream_byte%0d", i), acc[i], exp3[i]);
    chk("stream_ovr", overrun, 0);
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int r;
          r = $urandom_range(0, 9);
          if (r == 0) glitch($urandom_range(1, 6 * DIV));
          else if (r == 1) send_frame(8'($urandom), 0, -1);
          else if (r == 2) send_frame(8'($urandom), 1, $urandom_range(0, 7));
          else send_frame(8'($urandom), 1, -1);
          idle($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, BIT));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          rx_ready = $urandom_range(0, 3) == 0;
          idle(1);
        end
      end
    join
    rx_ready = 0;
    idle(BIT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
